seq_mult_unit: RTL and testbench

//  Iterative 32x32 shift-add multiplier sitting between the register file read ports and its

---
 rtl/seq_mult_unit_if.sv | 30 +++
 rtl/seq_mult_unit.sv | 121 ++++++++++++
 tb/tb_seq_mult_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_unit_if.sv
// Handshake and register-file bundle for the iterative multiplier.
// Master issues operands; slave (the multiplier) returns product and write port.
interface seq_mult_unit_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             START;
  logic [WIDTH-1:0] SRCA;
  logic [WIDTH-1:0] SRCB;
  logic [AW-1:0]    DEST;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] PRODLO;
  logic [WIDTH-1:0] PRODHI;
  logic [AW-1:0]    WA3;
  logic [WIDTH-1:0] WD3;
  logic             WE3;

  modport master (
    output START, SRCA, SRCB, DEST,
    input  BUSY, DONE, PRODLO, PRODHI,
    input  WA3, WD3, WE3
  );

  modport slave (
    input  START, SRCA, SRCB, DEST,
    output BUSY, DONE, PRODLO, PRODHI,
    output WA3, WD3, WE3
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative shift-add WIDTHxWIDTH multiplier writing the low word back.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_mult_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic CLK,
  input logic RESET,
  seq_mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [AW-1:0]      wa_q, wa_d;

  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step, fin;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  always_comb begin
    a_mag  = bus.SRCA[WIDTH-1] ? -bus.SRCA : bus.SRCA;
    b_mag  = bus.SRCB[WIDTH-1] ? -bus.SRCB : bus.SRCB;
    sign_d = sign_q;
    if (state_q == S_IDLE && bus.START)
      sign_d = bus.SRCA[WIDTH-1] ^ bus.SRCB[WIDTH-1];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sign_q <= 1'b0;
    else       sign_q <= sign_d;
  end
`else
  always_comb begin
    a_mag = bus.SRCA;
    b_mag = bus.SRCB;
  end
`endif

  // {carry, hi, multiplier} shifts right; product bits fill from the top
  always_comb begin
    addend = acc_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step   = {sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
    fin    = sign_q ? -step : step;
`else
    fin    = step;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    wa_d    = wa_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          wa_d    = bus.DEST;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          prod_d  = fin;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      wa_q    <= wa_d;
    end
  end

  assign bus.BUSY   = (state_q != S_IDLE);
  assign bus.DONE   = (state_q == S_DONE);
  assign bus.WE3    = (state_q == S_DONE) && (wa_q != '0);
  assign bus.WA3    = wa_q;
  assign bus.PRODLO = prod_q[WIDTH-1:0];
  assign bus.PRODHI = prod_q[2*WIDTH-1:WIDTH];
  assign bus.WD3    = prod_q[WIDTH-1:0];
endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: directed vectors queued on issue,
// checked by a negedge monitor whenever DONE appears.
module tb_seq_mult_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_unit_if #(.WIDTH(32), .AW(5)) bus();

  seq_mult_unit #(.WIDTH(32), .AW(5)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [4:0]  wa;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.WE3 && !bus.DONE)
        check("we3_without_done", 64'(bus.WE3), 64'd0);
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.DONE), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("prodhi", 64'(bus.PRODHI), 64'(mon_e.hi));
          check("prodlo", 64'(bus.PRODLO), 64'(mon_e.lo));
          check("wd3", 64'(bus.WD3), 64'(mon_e.lo));
          check("wa3", 64'(bus.WA3), 64'(mon_e.wa));
          check("we3", 64'(bus.WE3), 64'(mon_e.we));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0]  d,
                       input logic [31:0] hi,
                       input logic [31:0] lo);
    exp_t e;
    bus.START = 1'b1;
    bus.SRCA  = a;
    bus.SRCB  = b;
    bus.DEST  = d;
    e.cyc = cyc + 33;
    e.wa  = d;
    e.hi  = hi;
    e.lo  = lo;
    e.we  = (d != 5'd0);
    sb.push_back(e);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.BUSY), 64'd0);
    check({tag, "_done"}, 64'(bus.DONE), 64'd0);
    check({tag, "_we3"}, 64'(bus.WE3), 64'd0);
    check({tag, "_prodlo"}, 64'(bus.PRODLO), 64'd0);
    check({tag, "_prodhi"}, 64'(bus.PRODHI), 64'd0);
    check({tag, "_wa3"}, 64'(bus.WA3), 64'd0);
    check({tag, "_wd3"}, 64'(bus.WD3), 64'd0);
  endtask

  initial begin
    int   busy_n;
    int   lim;
    int unsigned c0;
    exp_t e;

    bus.START = 1'b0;
    bus.SRCA  = '0;
    bus.SRCB  = '0;
    bus.DEST  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic product, latency and busy width
    issue(32'd3, 32'd5, 5'd1, 32'h0, 32'hF);
    busy_n = 0;
    lim    = 0;
    while (bus.BUSY && lim < 100) begin
      busy_n++;
      @(negedge clk);
      lim++;
    end
    check("busy_cycles", 64'(busy_n), 64'd33);
    drain();

`ifdef SEQ_MULT_SIGNED_EN
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,
          32'h00000000, 32'h00000001);
    drain();
    issue(32'hFFFFFFFE, 32'd7, 5'd3,
          32'hFFFFFFFF, 32'hFFFFFFF2);
    drain();
    issue(32'h80000000, 32'd2, 5'd9,
          32'hFFFFFFFF, 32'h00000000);
    drain();
    issue(32'hFFFFFFFF, 32'd1, 5'd10,
          32'hFFFFFFFF, 32'hFFFFFFFF);
    drain();
`else
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,
          32'hFFFFFFFE, 32'h00000001);
    drain();
    issue(32'h80000000, 32'd2, 5'd9,
          32'h00000001, 32'h00000000);
    drain();
    issue(32'hFFFFFFFF, 32'd1, 5'd10,
          32'h00000000, 32'hFFFFFFFF);
    drain();
`endif
    issue(32'h0, 32'hDEADBEEF, 5'd31, 32'h0, 32'h0);
    drain();

    // START while busy is ignored; accept again at cycle 34
    issue(32'h11, 32'h3, 5'd2, 32'h0, 32'h33);
    repeat (4) @(negedge clk);
    bus.START = 1'b1;
    bus.SRCA  = 32'h55;
    bus.SRCB  = 32'h55;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (26) @(negedge clk);
    bus.START = 1'b1;
    bus.SRCA  = 32'h77;
    bus.SRCB  = 32'h77;
    @(negedge clk);
    bus.START = 1'b0;
    @(negedge clk);
    issue(32'd6, 32'd7, 5'd4, 32'h0, 32'd42);
    drain();

    // async reset mid-run aborts the operation
    issue(32'h1234, 32'h10, 5'd5, 32'h0, 32'h12340);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("abort");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd9, 5'd6, 32'h0, 32'd81);
    drain();

    // register 0 destination: no write enable
    issue(32'h10000, 32'h10000, 5'd0, 32'h1, 32'h0);
    drain();

    // START held high: back-to-back products 34 cycles apart
    c0        = cyc;
    bus.START = 1'b1;
    bus.SRCA  = 32'd2;
    bus.SRCB  = 32'd2;
    bus.DEST  = 5'd7;
    e.cyc = c0 + 33;
    e.wa  = 5'd7;
    e.hi  = 32'h0;
    e.lo  = 32'd4;
    e.we  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.SRCA = 32'd4;
    bus.SRCB = 32'd4;
    bus.DEST = 5'd8;
    e.cyc = c0 + 34 + 33;
    e.wa  = 5'd8;
    e.hi  = 32'h0;
    e.lo  = 32'd16;
    e.we  = 1'b1;
    sb.push_back(e);
    repeat (34) @(negedge clk);
    bus.START = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
